mac_array_seq: RTL and testbench
================================

Name: mac_array_seq

Overview:
- Sequencer for the 8x8 matrix-vector datapath: eight A-row FIFOs, one B-vector FIFO and a systolic chain of eight MACs.
- Accepts a serial load stream, steers each beat into the correct FIFO, clears the MACs, then issues skewed FIFO read requests so A[r][c] meets B[c] at MAC r.
- Waits for the pipeline to drain, then signals done. Results stay in the MAC accumulators; this block never reads them.

Parameters:
- ROWS, 8, number of A FIFOs / MAC stages.
- COLS, 8, vector length (entries per FIFO).
- DATA_WIDTH, 8, element width.
- DRAIN_CYCLES, 2, cycles after the last read before results are final (FIFO read latency + MAC register).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- ld_valid  in  1  load beat valid.
- ld_data  in  DATA_WIDTH  load beat.
- ld_ready  out  1  load beat accepted when ld_valid & ld_ready.
- a_full  in  ROWS  per-row A FIFO wrfull.
- a_empty  in  ROWS  per-row A FIFO rdempty.
- b_full  in  1  B FIFO wrfull.
- b_empty  in  1  B FIFO rdempty.
- a_wrreq  out  ROWS  A FIFO write strobes.
- b_wrreq  out  1  B FIFO write strobe.
- wdata  out  DATA_WIDTH  shared FIFO write data (= ld_data, combinational).
- a_rdreq  out  ROWS  A FIFO read strobes (skewed).
- b_rdreq  out  1  B FIFO read strobe, feeds MAC 0.
- fifo_clr  out  1  FIFO clear pulse.
- mac_clr  out  1  MAC accumulator clear pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky underflow flag.

Behaviour:
- States: IDLE, FLUSH, LOAD, CLR, RUN, DRAIN, DONE. Reset forces IDLE and clears all counters and err.
- All outputs are 0 while in IDLE after reset. Reset asserted mid-job returns to IDLE on the next edge and drops every strobe; FIFO contents are not touched until the next FLUSH.
- IDLE: start=1 -> FLUSH. Clear err on the same edge. start is ignored in all other states.
- FLUSH: fifo_clr=1 for exactly one cycle -> LOAD with ld_cnt=0.
- LOAD: beat k = ld_cnt, range 0 .. COLS+ROWS*COLS-1.
  - k < COLS: target is B.
  - Otherwise the target is A row (k-COLS)/COLS, row-major.
  - ld_ready = 1 unless the target FIFO's full flag is set.
  - On acceptance, pulse the target's wrreq in the same cycle and increment ld_cnt.
  - ld_valid=0 stalls with no penalty.
  - Acceptance of the last beat -> CLR. ld_ready is 0 outside LOAD.
- CLR: mac_clr=1 for one cycle -> RUN with run_cnt=0.
- RUN: lasts ROWS+COLS-1 cycles; t = run_cnt = 0 .. ROWS+COLS-2.
  - b_rdreq = (t < COLS).
  - a_rdreq[r] = (r <= t < r+COLS).
  - After t = ROWS+COLS-2 -> DRAIN.
- DRAIN: all rdreq low for DRAIN_CYCLES cycles -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- busy = (state != IDLE).
- err is set on any cycle where a_rdreq[r] & a_empty[r], or b_rdreq & b_empty. It holds until reset or the next accepted start.
- The sequence continues regardless of err; no retry.
- Counters: $clog2(COLS+ROWS*COLS+1) bits for ld_cnt, $clog2(ROWS+COLS) bits for run_cnt. Neither counter wraps within a job.
- Full flag asserted mid-LOAD (mis-sized FIFO): stall only, never drop or duplicate a beat.

Test Plan:
- Nominal, defaults, ld_valid held high, start at cycle 0 -> fifo_clr at cycle 1; ld_ready cycles 2..73; b_wrreq beats 0..7; a_wrreq[0] beats 8..15; a_wrreq[7] beats 64..71; mac_clr at 74; RUN 75..89; done at 92; busy 1..92.
- Skew check in RUN:
  - b_rdreq high cycles 75..82.
  - a_rdreq[0] high 75..82; a_rdreq[3] high 78..85; a_rdreq[7] high 82..89.
  - Each a_rdreq high exactly 8 cycles.
- Load backpressure: ld_valid toggled 1/0 plus a_full[2] forced high for 5 cycles at beat 24 -> ld_ready=0 during those cycles, no write strobes, exactly 72 writes total, done delayed accordingly.
- Underflow: hold a_empty[5]=1 throughout RUN -> err=1 from the first a_rdreq[5] cycle, stays 1 after done, clears on the next accepted start.
- Reset mid-RUN at t=6 -> next cycle state IDLE, all outputs 0. A following start runs a full job with done at start+92.
- start pulsed during LOAD and DRAIN -> ignored; timing identical to nominal.

Source files
------------

// File: rtl/mac_array_seq.sv
// rtl/mac_array_seq.sv - load/clear/skewed-read sequencer for the 8x8 matrix-vector MAC array
module mac_array_seq #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic [ROWS-1:0]       a_full,
  input  logic [ROWS-1:0]       a_empty,
  input  logic                  b_full,
  input  logic                  b_empty,
  output logic [ROWS-1:0]       a_wrreq,
  output logic                  b_wrreq,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ROWS-1:0]       a_rdreq,
  output logic                  b_rdreq,
  output logic                  fifo_clr,
  output logic                  mac_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int NBEATS = COLS + ROWS * COLS;
  localparam int LW     = $clog2(NBEATS + 1);
  localparam int RW     = $clog2(ROWS + COLS);
  localparam int DCW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LOAD, S_CLR, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   ld_cnt;
  logic [RW-1:0]   run_cnt;
  logic [DCW-1:0]  dr_cnt;
  logic            err_q;
  logic            tgt_b;
  logic            tgt_full;
  logic [LW-1:0]   a_off;
  logic [ROWS-1:0] a_sel;
  logic            underflow;

  // Beats 0..COLS-1 go to B, the rest fill the A rows in row-major order.
  always_comb begin
    tgt_b = (ld_cnt < LW'(COLS));
    a_off = ld_cnt - LW'(COLS);
    a_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (a_off / LW'(COLS) == LW'(r)) a_sel[r] = 1'b1;
    end
    tgt_full = tgt_b ? b_full : |(a_sel & a_full);
  end

  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    a_wrreq  = '0;
    b_wrreq  = 1'b0;
    wdata    = ld_data;
    a_rdreq  = '0;
    b_rdreq  = 1'b0;
    fifo_clr = 1'b0;
    mac_clr  = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nx = S_FLUSH;
      S_FLUSH: begin
        fifo_clr = 1'b1;
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = !tgt_full;
        if (ld_valid && !tgt_full) begin
          if (tgt_b) b_wrreq = 1'b1;
          else       a_wrreq = a_sel;
          if (ld_cnt == LW'(NBEATS - 1)) state_nx = S_CLR;
        end
      end
      S_CLR: begin
        mac_clr  = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // Row r starts r cycles late so A[r][c] meets B[c] as it ripples down the chain.
        b_rdreq = (run_cnt < RW'(COLS));
        for (int r = 0; r < ROWS; r++) begin
          a_rdreq[r] = (run_cnt >= RW'(r)) && (run_cnt < RW'(r + COLS));
        end
        if (run_cnt == RW'(ROWS + COLS - 2)) state_nx = S_DRAIN;
      end
      S_DRAIN: if (dr_cnt == DCW'(DRAIN_CYCLES - 1)) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign underflow = |(a_rdreq & a_empty) | (b_rdreq & b_empty);
  assign err       = err_q | underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ld_cnt  <= '0;
      run_cnt <= '0;
      dr_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_FLUSH: ld_cnt <= '0;
        S_LOAD:  if (ld_valid && ld_ready) ld_cnt <= ld_cnt + 1'b1;
        S_CLR: begin
          run_cnt <= '0;
          dr_cnt  <= '0;
        end
        S_RUN:   run_cnt <= run_cnt + 1'b1;
        S_DRAIN: dr_cnt <= dr_cnt + 1'b1;
        default: ;
      endcase
      if (state == S_IDLE && start) err_q <= 1'b0;
      else if (underflow)           err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_array_seq.sv
// tb/tb_mac_array_seq.sv - randomized self-checking bench for mac_array_seq
module tb_mac_array_seq;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int NB   = COLS + ROWS * COLS;
  localparam int RUNL = ROWS + COLS - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic [ROWS-1:0] a_full, a_empty, a_wrreq, a_rdreq;
  logic          b_full, b_empty, b_wrreq, b_rdreq;
  logic [DW-1:0] wdata;
  logic          fifo_clr, mac_clr, busy, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit m_err = 1'b0;
  int lat;

  mac_array_seq dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .a_full(a_full), .a_empty(a_empty), .b_full(b_full),
    .b_empty(b_empty), .a_wrreq(a_wrreq), .b_wrreq(b_wrreq), .wdata(wdata),
    .a_rdreq(a_rdreq), .b_rdreq(b_rdreq), .fifo_clr(fifo_clr), .mac_clr(mac_clr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_outs"}, {ld_ready, a_wrreq, b_wrreq, a_rdreq, b_rdreq,
                           fifo_clr, mac_clr, busy, done}, 0);
    check({tag, "_err"}, err, m_err);
  endtask

  // vmode: 0 valid always high, 1 valid toggled with random non-target full flags,
  // 2 valid and all full flags random. abort_t >= 0 pulses reset at that RUN step.
  task automatic run_job(input int vmode, input int full_beat, input int full_len,
                         input int empty_row, input bit extra_start, input int abort_t,
                         output int lat_o);
    int k, fcnt, wr, lcyc, s, row;
    bit tgt_b, tf, acc;
    logic [ROWS-1:0] expa;
    lat_o = -1;
    tick();
    start = 1'b1; a_empty = '1; b_empty = 1'b1;
    s = cyc;
    sample();
    check("idle_busy", busy, 0);
    check("idle_err", err, m_err);

    tick();
    start = 1'b0;
    m_err = 1'b0;
    sample();
    check("flush_clr", fifo_clr, 1);
    check("flush_ready", ld_ready, 0);
    check("flush_busy", busy, 1);
    check("flush_err", err, 0);

    k = 0; fcnt = 0; wr = 0; lcyc = 0;
    while (k < NB && lcyc < 2000) begin
      tick();
      lcyc++;
      tgt_b = (k < COLS);
      row   = tgt_b ? 0 : (k - COLS) / COLS;
      case (vmode)
        0:       ld_valid = 1'b1;
        1:       ld_valid = (lcyc % 2 == 1);
        default: ld_valid = 1'( $urandom_range(0, 1));
      endcase
      ld_data = DW'($urandom);
      a_full  = (vmode == 0) ? '0 : ROWS'($urandom);
      b_full  = (vmode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (vmode == 1) begin
        if (tgt_b) b_full = 1'b0;
        else       a_full[row] = 1'b0;
      end
      if (k == full_beat && fcnt < full_len) begin
        a_full[row] = 1'b1;
        fcnt++;
      end
      start = extra_start && (lcyc == 10);
      tf  = tgt_b ? b_full : a_full[row];
      acc = ld_valid && !tf;
      sample();
      check("ld_ready", ld_ready, !tf);
      check("b_wrreq", b_wrreq, acc && tgt_b);
      check("a_wrreq", a_wrreq, (acc && !tgt_b) ? (32'd1 << row) : 32'd0);
      check("wdata", wdata, ld_data);
      check("load_misc", {busy, fifo_clr, mac_clr, a_rdreq, b_rdreq, done}, {1'b1, 12'b0});
      wr += $countones(a_wrreq) + int'(b_wrreq);
      if (acc) k++;
    end
    if (k < NB) check("load_timeout", k, NB);
    check("write_total", wr, NB);

    tick();
    ld_valid = 1'b0; start = 1'b0; a_full = '0; b_full = 1'b0;
    sample();
    check("mac_clr", mac_clr, 1);
    check("clr_ready", ld_ready, 0);
    check("clr_wr", {a_wrreq, b_wrreq}, 0);

    for (int t = 0; t < RUNL; t++) begin
      tick();
      a_empty = (empty_row >= 0) ? ROWS'(1 << empty_row) : '0;
      b_empty = 1'b0;
      if (t == abort_t) rst = 1'b1;
      for (int r = 0; r < ROWS; r++) expa[r] = (t >= r) && (t < r + COLS);
      if (empty_row >= 0 && expa[empty_row]) m_err = 1'b1;
      sample();
      check("b_rdreq", b_rdreq, t < COLS);
      check("a_rdreq", a_rdreq, expa);
      check("run_err", err, m_err);
      check("run_misc", {mac_clr, ld_ready, done, busy, fifo_clr}, 5'b00010);
      if (t == abort_t) begin
        tick();
        rst = 1'b0;
        m_err = 1'b0;
        a_empty = '1; b_empty = 1'b1;
        sample();
        chk_idle("abort");
        return;
      end
    end

    for (int i = 0; i < 2; i++) begin
      tick();
      a_empty = '1; b_empty = 1'b1;
      start = extra_start && (i == 0);
      sample();
      check("drain_outs", {a_rdreq, b_rdreq, done, busy}, 11'b1);
      check("drain_err", err, m_err);
    end

    tick();
    start = 1'b0;
    sample();
    check("done", done, 1);
    check("done_busy", busy, 1);
    check("done_err", err, m_err);
    lat_o = cyc - s;
    check("done_lat", lat_o, lcyc + 20);

    tick();
    sample();
    chk_idle("post");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    a_full = '0; b_full = 1'b0; a_empty = '1; b_empty = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    sample();
    chk_idle("reset");
    check("reset_wdata", wdata, ld_data);

    run_job(0, -1, 0, -1, 1'b0, -1, lat);
    check("nominal_lat", lat, 92);
    run_job(0, -1, 0, -1, 1'b1, -1, lat);
    check("ignored_start_lat", lat, 92);
    run_job(1, 24, 5, -1, 1'b0, -1, lat);
    run_job(2, -1, 0, -1, 1'b0, -1, lat);
    run_job(0, -1, 0, 5, 1'b0, -1, lat);
    check("uflow_sticky", err, 1);
    run_job(0, -1, 0, -1, 1'b0, -1, lat);
    check("uflow_cleared", err, 0);
    run_job(0, -1, 0, -1, 1'b0, 6, lat);
    run_job(0, -1, 0, -1, 1'b0, -1, lat);
    check("after_abort_lat", lat, 92);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
